alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 128 ++++++++++++
 tb/tb_alu_arbiter.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a shared combinational ALU (IDLE/EXEC/RESP).
// Define ALU_ARBITER_OPCHECK_EN to respond to opcodes 011/100/101 with rsp_err instead of executing them.
module alu_arbiter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  input  logic [2:0]   req0_op,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  input  logic [2:0]   req1_op,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  output logic [2:0]   alu_op,
  input  logic [W-1:0] alu_z,
  input  logic         alu_ex,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_id,
  output logic [W-1:0] rsp_z,
  output logic         rsp_ex,
  output logic         rsp_err
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]   state;
  logic         last_gnt;
  logic         gnt_any;
  logic         gnt_id;
  logic [W-1:0] sel_a;
  logic [W-1:0] sel_b;
  logic [2:0]   sel_op;
  logic         illegal;

  // Grant only while out of reset and idle; on contention favour whoever was not served last.
  always_comb begin
    gnt_any = 1'b0;
    gnt_id  = 1'b0;
    if (rst_n && state == IDLE) begin
      if (req0_valid && req1_valid) begin
        gnt_any = 1'b1;
        gnt_id  = ~last_gnt;
      end else if (req0_valid) begin
        gnt_any = 1'b1;
        gnt_id  = 1'b0;
      end else if (req1_valid) begin
        gnt_any = 1'b1;
        gnt_id  = 1'b1;
      end
    end
  end

  assign req0_ready = gnt_any && !gnt_id;
  assign req1_ready = gnt_any && gnt_id;
  assign sel_a      = gnt_id ? req1_a  : req0_a;
  assign sel_b      = gnt_id ? req1_b  : req0_b;
  assign sel_op     = gnt_id ? req1_op : req0_op;
  assign rsp_valid  = (state == RESP);

`ifdef ALU_ARBITER_OPCHECK_EN
  assign illegal = (sel_op == 3'b011) || (sel_op == 3'b100) || (sel_op == 3'b101);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_err <= 1'b0;
    end else if (gnt_any) begin
      rsp_err <= illegal;
    end
  end
`else
  assign illegal = 1'b0;
  assign rsp_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      last_gnt <= 1'b1;
      rsp_id   <= 1'b0;
      rsp_z    <= '0;
      rsp_ex   <= 1'b0;
      alu_a    <= '0;
      alu_b    <= '0;
      alu_op   <= 3'b000;
    end else begin
      case (state)
        IDLE: begin
          if (gnt_any) begin
            last_gnt <= gnt_id;
            rsp_id   <= gnt_id;
            if (illegal) begin
              // Rejected ops leave the ALU operands untouched and answer immediately.
              rsp_z  <= '0;
              rsp_ex <= 1'b0;
              state  <= RESP;
            end else begin
              alu_a  <= sel_a;
              alu_b  <= sel_b;
              alu_op <= sel_op;
              state  <= EXEC;
            end
          end
        end
        EXEC: begin
          rsp_z  <= alu_z;
          rsp_ex <= alu_ex;
          state  <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Randomized and directed checks of alu_arbiter against a transaction-level model of arbitration and ALU results.
module tb_alu_arbiter;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req0_valid, req1_valid;
  logic         req0_ready, req1_ready;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [2:0]   req0_op, req1_op;
  logic [W-1:0] alu_a, alu_b, alu_z;
  logic [2:0]   alu_op;
  logic         alu_ex;
  logic         rsp_valid, rsp_ready, rsp_id, rsp_ex, rsp_err;
  logic [W-1:0] rsp_z;

  int n_cmp  = 0;
  int n_fail = 0;

  // Model state: who was served last, and what the ALU port should currently hold.
  int           last_g = 1;
  logic [W-1:0] m_alu_a  = '0;
  logic [W-1:0] m_alu_b  = '0;
  logic [2:0]   m_alu_op = 3'b000;

  always #5 clk = ~clk;

  alu_arbiter #(.W(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_z(alu_z), .alu_ex(alu_ex),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_z(rsp_z),
    .rsp_ex(rsp_ex), .rsp_err(rsp_err)
  );

  function automatic logic [W-1:0] alu_fn(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op);
    case (op)
      3'b000:  return a & b;
      3'b001:  return a | b;
      3'b010:  return a + b;
      3'b110:  return a - b;
      3'b111:  return ($signed(a) < $signed(b)) ? W'(1) : W'(0);
      default: return a ^ b;
    endcase
  endfunction

  // Stand-in for the shared ALU sitting outside the arbiter.
  always_comb begin
    alu_z  = alu_fn(alu_a, alu_b, alu_op);
    alu_ex = (alu_z == '0);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit is_illegal(input logic [2:0] op);
`ifdef ALU_ARBITER_OPCHECK_EN
    return (op == 3'b011) || (op == 3'b100) || (op == 3'b101);
`else
    return 1'b0;
`endif
  endfunction

  task automatic do_txn(input bit v0, input bit v1,
                        input logic [W-1:0] a0, input logic [W-1:0] b0, input logic [2:0] op0,
                        input logic [W-1:0] a1, input logic [W-1:0] b1, input logic [2:0] op1,
                        input int hold);
    int g;
    bit ill;
    logic [W-1:0] ez;
    logic [W-1:0] ga, gb;
    logic [2:0]   gop;
    @(negedge clk);
    req0_valid = v0; req0_a = a0; req0_b = b0; req0_op = op0;
    req1_valid = v1; req1_a = a1; req1_b = b1; req1_op = op1;
    rsp_ready  = 1'b0;
    #1;
    if (v0 && v1) g = (last_g == 0) ? 1 : 0;
    else if (v0)  g = 0;
    else if (v1)  g = 1;
    else          g = -1;
    check("req0_ready_idle", 64'(req0_ready), 64'(g == 0));
    check("req1_ready_idle", 64'(req1_ready), 64'(g == 1));
    if (g < 0) begin
      @(posedge clk);
      @(negedge clk);
      #1;
      check("no_rsp_without_req", 64'(rsp_valid), 64'd0);
      return;
    end
    ga  = (g == 0) ? a0 : a1;
    gb  = (g == 0) ? b0 : b1;
    gop = (g == 0) ? op0 : op1;
    last_g = g;
    ill = is_illegal(gop);
    if (ill) begin
      ez = '0;
    end else begin
      ez = alu_fn(ga, gb, gop);
      m_alu_a = ga; m_alu_b = gb; m_alu_op = gop;
    end
    @(posedge clk);
    @(negedge clk);
    req0_valid = $urandom_range(0, 1);
    req1_valid = $urandom_range(0, 1);
    #1;
    check("alu_a", 64'(alu_a), 64'(m_alu_a));
    check("alu_b", 64'(alu_b), 64'(m_alu_b));
    check("alu_op", 64'(alu_op), 64'(m_alu_op));
    if (!ill) begin
      check("rsp_valid_exec", 64'(rsp_valid), 64'd0);
      check("ready_exec", 64'({req0_ready, req1_ready}), 64'd0);
      @(posedge clk);
      @(negedge clk);
      #1;
    end
    check("rsp_valid_resp", 64'(rsp_valid), 64'd1);
    check("rsp_id", 64'(rsp_id), 64'(g));
    check("rsp_z", 64'(rsp_z), 64'(ez));
    check("rsp_ex", 64'(rsp_ex), 64'(!ill && ez == '0));
    check("rsp_err", 64'(rsp_err), 64'(ill));
    for (int i = 0; i < hold; i++) begin
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      #1;
      check("rsp_valid_hold", 64'(rsp_valid), 64'd1);
      check("rsp_z_hold", 64'(rsp_z), 64'(ez));
      check("rsp_id_hold", 64'(rsp_id), 64'(g));
      check("ready_resp", 64'({req0_ready, req1_ready}), 64'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready  = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    #1;
    check("rsp_valid_after_hs", 64'(rsp_valid), 64'd0);
    $display("txn v=%0d%0d grant=%0d op=%03b a=%0h b=%0h z=%0h err=%0d hold=%0d",
             v0, v1, g, gop, ga, gb, rsp_z, rsp_err, hold);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
    check({tag, "_rsp_id"}, 64'(rsp_id), 64'd0);
    check({tag, "_rsp_z"}, 64'(rsp_z), 64'd0);
    check({tag, "_rsp_ex"}, 64'(rsp_ex), 64'd0);
    check({tag, "_rsp_err"}, 64'(rsp_err), 64'd0);
    check({tag, "_alu"}, {alu_a, alu_b[28:0], alu_op}, 64'd0);
    check({tag, "_ready"}, 64'({req0_ready, req1_ready}), 64'd0);
  endtask

  initial begin
    logic [2:0] ops [5] = '{3'b000, 3'b001, 3'b010, 3'b110, 3'b111};
    rst_n = 1'b0; rsp_ready = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_a = '0; req0_b = '0; req0_op = 3'b010;
    req1_a = '0; req1_b = '0; req1_op = 3'b010;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;

    // Both requesters contending from reset: grants alternate starting with 0.
    for (int i = 0; i < 4; i++)
      do_txn(1, 1, W'(7), W'(2), 3'b110, W'(3), W'(5), 3'b110, 0);

    do_txn(1, 0, W'(5), W'(3), 3'b010, '0, '0, 3'b000, 0);
    do_txn(0, 1, '0, '0, 3'b000, '1, W'(2), 3'b111, 4);
    do_txn(0, 1, '0, '0, 3'b000, W'(9), W'(6), 3'b100, 1);
    do_txn(0, 0, '0, '0, 3'b000, '0, '0, 3'b000, 0);

    // Reset while the op is in EXEC: transaction is dropped, arbitration restarts.
    @(negedge clk);
    req0_valid = 1'b1; req0_a = W'(11); req0_b = W'(4); req0_op = 3'b010;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    req1_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    #1;
    check_reset_outputs("rst_exec");
    last_g = 1; m_alu_a = '0; m_alu_b = '0; m_alu_op = 3'b000;
    rst_n = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
      #1;
      check("rst_exec_no_rsp", 64'(rsp_valid), 64'd0);
    end
    do_txn(1, 1, W'(1), W'(1), 3'b000, W'(2), W'(2), 3'b001, 0);

    for (int i = 0; i < 40; i++) begin
      logic [2:0] o0, o1;
      o0 = (i % 4 == 3) ? 3'($urandom_range(0, 7)) : ops[$urandom_range(0, 4)];
      o1 = (i % 5 == 4) ? 3'($urandom_range(0, 7)) : ops[$urandom_range(0, 4)];
      do_txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             (i % 3 == 0) ? W'($urandom_range(0, 8)) : W'($urandom), W'($urandom_range(0, 8)), o0,
             W'($urandom), (i % 2 == 0) ? W'($urandom) : W'($urandom_range(0, 3)), o1,
             $urandom_range(0, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
